spad_ring_buffer: RTL and testbench
===================================

Name: spad_ring_buffer

Overview:
Parametrised scratch pad for the PE datapath, the next generation of the single-port register-array spad. Adds multiple read ports, selectable read latency, and a ring (sliding-window) mode for ifmap/psum row reuse. In ring mode, writes append at a tail pointer and reads are offsets from a head pointer. A pop command slides the window by a programmable amount.

Parameters:
DATA_WIDTH, 16, data bit width
DEPTH, 12, number of entries; need not be a power of two
NUM_RD, 2, number of independent read ports (1..4)
RD_LATENCY, 1, read latency in cycles; 0 = combinational, 1 = registered
ADDR_WIDTH, $clog2(DEPTH), address/offset width
CNT_WIDTH, $clog2(DEPTH+1), occupancy width

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  synchronous, active-low reset
mode  in  1  0 = direct (absolute addressing), 1 = ring
clear  in  1  synchronous flush of head, tail and count; array contents untouched
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_addr  in  ADDR_WIDTH  absolute write address (direct mode only)
wr_data  in  DATA_WIDTH  write data
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*ADDR_WIDTH  per-port address (direct) or head offset (ring); port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  out  NUM_RD*DATA_WIDTH  per-port read data, same packing
rd_valid  out  NUM_RD  per-port read data valid
pop  in  1  ring mode: slide window
pop_cnt  in  CNT_WIDTH  entries to discard on pop
count  out  CNT_WIDTH  current occupancy (ring mode)
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (rstn=0 at edge): all entries cleared to 0; head=tail=count=0; rd_data=0 and rd_valid=0 when RD_LATENCY=1. Outputs after reset: wr_ready=1, empty=1, full=0. Reset overrides clear, pop and writes.
- Direct mode:
  - wr_ready=1 always; an accepted write stores wr_data at wr_addr.
  - wr_addr >= DEPTH: write dropped.
  - A read is in range when rd_addr < DEPTH.
  - pop is ignored; head, tail and count hold.
- Ring mode:
  - wr_ready = !full, evaluated before any same-cycle pop. A write while full is refused even if pop is asserted in that cycle.
  - An accepted write stores at tail; tail advances to (tail+1) mod DEPTH; wr_addr is ignored.
  - Read of port i targets (head + offset) mod DEPTH and is in range only if offset < count.
  - pop discards n = min(pop_cnt, count) entries: head advances to (head+n) mod DEPTH. pop_cnt=0 is a no-op.
  - Write and pop in the same cycle: count_next = count + accepted - n.
  - Wrap-around uses explicit compare-and-subtract; no power-of-two masking.
- Read timing:
  - RD_LATENCY=0: rd_data is combinational from the array. rd_valid[i] = rd_en[i] && in_range.
  - RD_LATENCY=1: rd_data and rd_valid are registered one cycle after rd_en. rd_data holds its last value when rd_en=0.
  - Out-of-range reads return rd_data=0 with rd_valid=0.
- Read-during-write to the same entry returns the old data at both latencies (read-before-write). For latency 1, range is evaluated against the pre-update count.
- All read ports are independent and may target the same entry at once.
- clear: head=tail=count=0 at the next edge. clear has priority over write and pop in the same cycle. Array contents are retained.
- mode may change only when empty (a protocol rule; the bench checks it with an assertion). Pointers are not altered by a mode change.
- full and empty are combinational from count.

Test Plan:
- Reset then direct mode: write 0xA5A5 to addr 3 and 0x1234 to addr 11; port0 reads addr 3 and port1 reads addr 11 -> next cycle (lat 1) rd_data = 0xA5A5 / 0x1234, rd_valid=11; read addr 12 -> rd_valid=0, rd_data=0.
- Ring fill: 12 writes of data 1..12 -> full=1, wr_ready=0; 13th write refused and count stays 12; offset 0 reads 1, offset 11 reads 12.
- Wrap-around: from full, pop with pop_cnt=5 -> count=7, head=5; write 100,101,102 (tail wraps to 0..2) -> count=10; offset 9 reads 102; offset 10 -> rd_valid=0.
- Simultaneous write and pop at count=4: pop_cnt=2 plus one write -> count=3. Over-pop with pop_cnt=9 at count=3 -> count=0, empty=1.
- Read-during-write: write 0x00FF to an entry holding 0x0F0F while reading it -> rd_data=0x0F0F that cycle, 0x00FF on the next read; repeat with RD_LATENCY=0.
- clear with write and pop in the same cycle -> count=0, empty=1, no write stored. rstn low mid-fill -> all outputs at reset values next cycle and every entry reads 0 in direct mode.

Source files
------------

// File: rtl/spad_ring_buffer.sv
// spad_ring_buffer: multi-port register-array scratch pad for the PE datapath.
// Two addressing modes share one array. In direct mode every port addresses
// an absolute entry. In ring mode the array is a sliding window: writes append
// at a tail pointer, reads are offsets from a head pointer, and pop slides the
// head forward. DEPTH need not be a power of two, so every pointer wrap is an
// explicit compare-and-subtract. Read latency is 0 (combinational) or 1
// (registered). Both latencies return the old data on a read-during-write.

module spad_ring_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 12,
    parameter int NUM_RD     = 2,
    parameter int RD_LATENCY = 1,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_mode,
    input  logic                         i_clear,
    input  logic                         i_wrValid,
    output logic                         o_wrReady,
    input  logic [ADDR_WIDTH-1:0]        i_wrAddr,
    input  logic [DATA_WIDTH-1:0]        i_wrData,
    input  logic [NUM_RD-1:0]            i_rdEn,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] i_rdAddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] o_rdData,
    output logic [NUM_RD-1:0]            o_rdValid,
    input  logic                         i_pop,
    input  logic [CNT_WIDTH-1:0]         i_popCnt,
    output logic [CNT_WIDTH-1:0]         o_count,
    output logic                         o_full,
    output logic                         o_empty
);

    // One extra bit over the occupancy width holds pointer + step without
    // overflow, because both operands stay below 2*DEPTH.
    localparam int SUM_WIDTH = CNT_WIDTH + 1;
    localparam logic [SUM_WIDTH-1:0] L_DEPTH_SUM = SUM_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] L_DEPTH_CNT = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_head;
    logic [ADDR_WIDTH-1:0] r_tail;
    logic [CNT_WIDTH-1:0]  r_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wrReady;
    logic                  w_wrAccept;
    logic                  w_wrInRange;
    logic [ADDR_WIDTH-1:0] w_wrIndex;
    logic                  w_ringWrite;
    logic [CNT_WIDTH-1:0]  w_popN;
    logic [SUM_WIDTH-1:0]  w_countSum;
    logic [CNT_WIDTH-1:0]  w_countNext;
    logic [ADDR_WIDTH-1:0] w_headNext;
    logic [ADDR_WIDTH-1:0] w_tailNext;

    logic [ADDR_WIDTH-1:0] w_rdOffset [NUM_RD];
    logic [ADDR_WIDTH-1:0] w_rdIndex  [NUM_RD];
    logic [DATA_WIDTH-1:0] w_rdWord   [NUM_RD];
    logic [NUM_RD-1:0]     w_rdInRange;

    // Advance a pointer by step entries, wrapping with a single subtract.
    // Callers guarantee base < DEPTH and step <= DEPTH whenever the result
    // is actually used.
    function automatic logic [ADDR_WIDTH-1:0] wrapAdd(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [SUM_WIDTH-1:0]  step
    );
        logic [SUM_WIDTH-1:0] sum;
        sum = SUM_WIDTH'(base) + step;
        if (sum >= L_DEPTH_SUM) begin
            sum = sum - L_DEPTH_SUM;
        end
        return ADDR_WIDTH'(sum);
    endfunction

    // Status flags come straight from the occupancy register.
    assign w_full  = (r_count == L_DEPTH_CNT);
    assign w_empty = (r_count == '0);

    // Write handshake. The ring-mode ready looks at the current count only,
    // so a same-cycle pop cannot make room for a write while full.
    assign w_wrReady   = i_mode ? !w_full : 1'b1;
    assign w_wrAccept  = i_wrValid && w_wrReady;
    assign w_wrInRange = i_mode || (SUM_WIDTH'(i_wrAddr) < L_DEPTH_SUM);
    assign w_wrIndex   = i_mode ? r_tail : i_wrAddr;
    assign w_ringWrite = i_mode && w_wrAccept;

    // A pop discards at most the entries currently held.
    always_comb begin
        w_popN = '0;
        if (i_mode && i_pop) begin
            w_popN = (i_popCnt < r_count) ? i_popCnt : r_count;
        end
    end

    // Next-state pointer and occupancy arithmetic. The count never goes
    // negative because the pop amount is bounded by the current count.
    assign w_countSum  = SUM_WIDTH'(r_count) + SUM_WIDTH'(w_ringWrite) - SUM_WIDTH'(w_popN);
    assign w_countNext = CNT_WIDTH'(w_countSum);
    assign w_headNext  = wrapAdd(r_head, SUM_WIDTH'(w_popN));
    assign w_tailNext  = wrapAdd(r_tail, SUM_WIDTH'(1));

    // Pointer and occupancy registers. Clear beats write and pop. Direct mode
    // leaves the ring state untouched so a mode change never moves pointers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_mode) begin
            r_head  <= w_headNext;
            r_count <= w_countNext;
            if (w_wrAccept) begin
                r_tail <= w_tailNext;
            end
        end
    end

    // Storage array. Reset zeroes every entry. Clear only flushes pointers and
    // also suppresses a same-cycle write. Out-of-range direct writes are dropped.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_mem[e] <= '0;
            end
        end else if (!i_clear && w_wrAccept && w_wrInRange) begin
            r_mem[w_wrIndex] <= i_wrData;
        end
    end

    // Per-port address decode. Ring reads are valid only below the current
    // occupancy. The index is forced to 0 when out of range, so the array is
    // never indexed past DEPTH.
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rdDecode
        assign w_rdOffset[g]  = i_rdAddr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_rdInRange[g] = i_mode ? (CNT_WIDTH'(w_rdOffset[g]) < r_count)
                                       : (SUM_WIDTH'(w_rdOffset[g]) < L_DEPTH_SUM);
        assign w_rdIndex[g]   = !w_rdInRange[g] ? '0
                              : (i_mode ? wrapAdd(r_head, SUM_WIDTH'(w_rdOffset[g]))
                                        : w_rdOffset[g]);
        assign w_rdWord[g]    = w_rdInRange[g] ? r_mem[w_rdIndex[g]] : '0;
    end

    if (RD_LATENCY == 0) begin : g_rdComb
        // Combinational read path. The array updates only at the edge, so a
        // same-cycle write is not yet visible and the old data is returned.
        for (genvar g = 0; g < NUM_RD; g++) begin : g_port
            assign o_rdValid[g] = i_rdEn[g] && w_rdInRange[g];
            assign o_rdData[g*DATA_WIDTH +: DATA_WIDTH] =
                o_rdValid[g] ? w_rdWord[g] : '0;
        end
    end else begin : g_rdReg
        logic [DATA_WIDTH-1:0] r_rdData [NUM_RD];
        logic [NUM_RD-1:0]     r_rdValid;

        // Registered read path. Data and range are sampled before this edge's
        // write and count update. Data holds while the port is idle.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                for (int p = 0; p < NUM_RD; p++) begin
                    r_rdData[p] <= '0;
                end
                r_rdValid <= '0;
            end else begin
                for (int p = 0; p < NUM_RD; p++) begin
                    if (i_rdEn[p]) begin
                        r_rdData[p]  <= w_rdWord[p];
                        r_rdValid[p] <= w_rdInRange[p];
                    end else begin
                        r_rdValid[p] <= 1'b0;
                    end
                end
            end
        end

        for (genvar g = 0; g < NUM_RD; g++) begin : g_port
            assign o_rdData[g*DATA_WIDTH +: DATA_WIDTH] = r_rdData[g];
        end
        assign o_rdValid = r_rdValid;
    end

    assign o_wrReady = w_wrReady;
    assign o_count   = r_count;
    assign o_full    = w_full;
    assign o_empty   = w_empty;

endmodule

// File: tb/tb_spad_ring_buffer.sv
// tb_spad_ring_buffer: directed bench for spad_ring_buffer. One instance uses
// registered reads and a second uses combinational reads. Both share all
// inputs, so every read vector checks both latencies.

module tb_spad_ring_buffer;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 4;

    logic            clk;
    logic            rstn;
    logic            mode;
    logic            clear;
    logic            wrValid;
    logic [AW-1:0]   wrAddr;
    logic [DW-1:0]   wrData;
    logic [1:0]      rdEn;
    logic [2*AW-1:0] rdAddr;
    logic            pop;
    logic [CW-1:0]   popCnt;

    logic            wrReady1, wrReady0;
    logic [2*DW-1:0] rdData1, rdData0;
    logic [1:0]      rdValid1, rdValid0;
    logic [CW-1:0]   count1, count0;
    logic            full1, full0;
    logic            empty1, empty0;

    int checkCount = 0;
    int errorCount = 0;
    logic prevMode = 1'b0;

    spad_ring_buffer #(.DATA_WIDTH(DW), .DEPTH(12), .NUM_RD(2), .RD_LATENCY(1)) u_dutLat1 (
        .clk(clk), .rstn(rstn), .i_mode(mode), .i_clear(clear),
        .i_wrValid(wrValid), .o_wrReady(wrReady1), .i_wrAddr(wrAddr), .i_wrData(wrData),
        .i_rdEn(rdEn), .i_rdAddr(rdAddr), .o_rdData(rdData1), .o_rdValid(rdValid1),
        .i_pop(pop), .i_popCnt(popCnt), .o_count(count1), .o_full(full1), .o_empty(empty1)
    );

    spad_ring_buffer #(.DATA_WIDTH(DW), .DEPTH(12), .NUM_RD(2), .RD_LATENCY(0)) u_dutLat0 (
        .clk(clk), .rstn(rstn), .i_mode(mode), .i_clear(clear),
        .i_wrValid(wrValid), .o_wrReady(wrReady0), .i_wrAddr(wrAddr), .i_wrData(wrData),
        .i_rdEn(rdEn), .i_rdAddr(rdAddr), .o_rdData(rdData0), .o_rdValid(rdValid0),
        .i_pop(pop), .i_popCnt(popCnt), .o_count(count0), .o_full(full0), .o_empty(empty0)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol rule: mode may only change while the buffer is empty.
    always @(posedge clk) begin
        if (rstn && (mode !== prevMode)) begin
            assert (empty1) else $error("[TB] mode changed while not empty");
        end
        prevMode <= mode;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge and settle just past it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        clear   = 1'b0;
        wrValid = 1'b0;
        wrAddr  = '0;
        wrData  = '0;
        rdEn    = '0;
        rdAddr  = '0;
        pop     = 1'b0;
        popCnt  = '0;
    endtask

    task automatic writeEntry(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wrValid = 1'b1;
        wrAddr  = addr;
        wrData  = data;
        applyStimulus();
        wrValid = 1'b0;
    endtask

    task automatic popEntries(input logic [CW-1:0] n);
        pop    = 1'b1;
        popCnt = n;
        applyStimulus();
        pop    = 1'b0;
        popCnt = '0;
    endtask

    // Read both ports. The combinational instance is checked before the edge
    // and the registered instance just after it.
    task automatic readCheck(input string tag, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [1:0] expValid, input logic [31:0] expData);
        rdEn   = 2'b11;
        rdAddr = {a1, a0};
        #1;
        checkOutput({tag, " lat0 valid"}, 32'(rdValid0), 32'(expValid));
        checkOutput({tag, " lat0 data"},  rdData0, expData);
        applyStimulus();
        checkOutput({tag, " lat1 valid"}, 32'(rdValid1), 32'(expValid));
        checkOutput({tag, " lat1 data"},  rdData1, expData);
        rdEn = 2'b00;
    endtask

    initial begin
        rstn = 1'b0;
        mode = 1'b0;
        idleInputs();
        applyStimulus();
        applyStimulus();
        rstn = 1'b1;

        // Reset state.
        checkOutput("reset wrReady", 32'(wrReady1), 32'd1);
        checkOutput("reset empty",   32'(empty1),   32'd1);
        checkOutput("reset full",    32'(full1),    32'd0);
        checkOutput("reset count",   32'(count1),   32'd0);
        checkOutput("reset rdValid", 32'(rdValid1), 32'd0);
        checkOutput("reset rdData",  rdData1,       32'd0);

        // Direct mode writes and reads, including an out-of-range address.
        writeEntry(4'd3,  16'hA5A5);
        writeEntry(4'd11, 16'h1234);
        readCheck("direct rd 3/11", 4'd3, 4'd11, 2'b11, {16'h1234, 16'hA5A5});
        readCheck("direct rd 12/3", 4'd12, 4'd3, 2'b10, {16'hA5A5, 16'h0000});

        // Ring fill to full, then a refused 13th write.
        mode = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            writeEntry(4'd0, DW'(i));
        end
        checkOutput("fill count",   32'(count1),   32'd12);
        checkOutput("fill count0",  32'(count0),   32'd12);
        checkOutput("fill full",    32'(full1),    32'd1);
        checkOutput("fill wrReady", 32'(wrReady1), 32'd0);
        wrValid = 1'b1;
        wrData  = 16'd99;
        pop     = 1'b1;
        popCnt  = 4'd0;
        applyStimulus();
        idleInputs();
        checkOutput("refused write count", 32'(count1), 32'd12);
        readCheck("ring rd off 0/11", 4'd0, 4'd11, 2'b11, {16'd12, 16'd1});

        // Wrap-around: pop 5 (head=5), append three entries that wrap the tail.
        popEntries(4'd5);
        checkOutput("pop5 count", 32'(count1), 32'd7);
        writeEntry(4'd0, 16'd100);
        writeEntry(4'd0, 16'd101);
        writeEntry(4'd0, 16'd102);
        checkOutput("wrap count", 32'(count1), 32'd10);
        readCheck("wrap rd off 9/10", 4'd9, 4'd10, 2'b01, {16'h0000, 16'd102});
        readCheck("wrap rd off 0/6",  4'd0, 4'd6,  2'b11, {16'd12, 16'd6});

        // Simultaneous write and pop at count 4, then over-pop.
        popEntries(4'd6);
        checkOutput("pop6 count", 32'(count1), 32'd4);
        pop     = 1'b1;
        popCnt  = 4'd2;
        wrValid = 1'b1;
        wrData  = 16'd200;
        applyStimulus();
        idleInputs();
        checkOutput("wr+pop count", 32'(count1), 32'd3);
        readCheck("wr+pop rd off 2/0", 4'd2, 4'd0, 2'b11, {16'd101, 16'd200});
        popEntries(4'd9);
        checkOutput("overpop count", 32'(count1), 32'd0);
        checkOutput("overpop empty", 32'(empty1), 32'd1);
        checkOutput("overpop empty0", 32'(empty0), 32'd1);

        // Read-during-write returns old data, new data on the following read.
        mode = 1'b0;
        writeEntry(4'd5, 16'h0F0F);
        wrValid = 1'b1;
        wrAddr  = 4'd5;
        wrData  = 16'h00FF;
        readCheck("rdw old", 4'd5, 4'd5, 2'b11, {16'h0F0F, 16'h0F0F});
        idleInputs();
        readCheck("rdw new", 4'd5, 4'd5, 2'b11, {16'h00FF, 16'h00FF});

        // Ring write at count 0 with a same-cycle read of offset 0: the range
        // uses the pre-write count, so the read is invalid.
        mode    = 1'b1;
        wrValid = 1'b1;
        wrData  = 16'h7777;
        readCheck("ring rd at count0", 4'd0, 4'd0, 2'b00, 32'd0);
        idleInputs();
        checkOutput("ring count after wr", 32'(count1), 32'd1);

        // Clear with write and pop in the same cycle.
        clear   = 1'b1;
        wrValid = 1'b1;
        wrData  = 16'h5555;
        pop     = 1'b1;
        popCnt  = 4'd1;
        applyStimulus();
        idleInputs();
        checkOutput("clear count", 32'(count1), 32'd0);
        checkOutput("clear empty", 32'(empty1), 32'd1);
        mode = 1'b0;
        readCheck("clear no write", 4'd5, 4'd4, 2'b11, {16'h7777, 16'h00FF});

        // Reset mid-fill with a write still requested.
        mode = 1'b1;
        writeEntry(4'd0, 16'h1111);
        writeEntry(4'd0, 16'h2222);
        wrValid = 1'b1;
        wrData  = 16'h3333;
        rdEn    = 2'b01;
        rdAddr  = '0;
        applyStimulus();
        idleInputs();
        checkOutput("prefill rdData", 32'(rdData1[DW-1:0]), 32'h1111);
        checkOutput("prefill count",  32'(count1), 32'd3);
        rstn    = 1'b0;
        wrValid = 1'b1;
        wrData  = 16'h4444;
        applyStimulus();
        rstn = 1'b1;
        idleInputs();
        checkOutput("midreset count",   32'(count1),   32'd0);
        checkOutput("midreset empty",   32'(empty1),   32'd1);
        checkOutput("midreset full",    32'(full1),    32'd0);
        checkOutput("midreset wrReady", 32'(wrReady1), 32'd1);
        checkOutput("midreset rdValid", 32'(rdValid1), 32'd0);
        checkOutput("midreset rdData",  rdData1,       32'd0);
        mode = 1'b0;
        for (int i = 0; i < 12; i++) begin
            readCheck($sformatf("zeroed entry %0d", i), AW'(i), AW'(11 - i), 2'b11, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
